fbu_ram_responder: RTL and testbench



---
 rtl/fbu_ram_responder.sv | 122 ++++++++++++
 tb/tb_fbu_ram_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fbu_ram_responder.sv
// fbu_ram_responder: word RAM behind the FBU core's MAR/RAMWr/MDRIn/MDROut bus.
// It has one-cycle registered reads, and a loader front end that fills the RAM
// from a valid/ready stream while the core is held in reset.
// Optional build macro: FBU_RAM_WPROT_EN blocks CPU writes below PROT_LIMIT
// and reports each blocked write on wr_fault.
//
// state  | meaning
// S_LOAD | loader owns the RAM, core held in reset, CPU bus ignored
// S_RUN  | core owns the RAM, loader stream ignored
module fbu_ram_responder #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10,
    parameter int PROT_LIMIT    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] MAR,
    input  logic                     RAMWr,
    input  logic [DATA_WIDTH-1:0]    MDRIn,
    output logic [DATA_WIDTH-1:0]    MDROut,
    input  logic                     ld_valid,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     ld_last,
    output logic                     ld_ready,
    output logic                     cpu_rst,
    output logic [ADDRESS_WIDTH:0]   loaded_count,
    output logic                     wr_fault
);

    localparam int                   LP_DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0]   LP_FULL  = LP_DEPTH[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH-1:0] LP_TOP   = {ADDRESS_WIDTH{1'b1}};
`ifdef FBU_RAM_WPROT_EN
    localparam logic LP_WPROT_EN = 1'b1;
`else
    localparam logic LP_WPROT_EN = 1'b0;
`endif

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_ld_addr;
    logic [ADDRESS_WIDTH:0]   r_loaded_count;
    logic [DATA_WIDTH-1:0]    r_mem [LP_DEPTH];
    logic [DATA_WIDTH-1:0]    r_mdrout;
    logic                     r_wr_fault;
    logic                     w_xfer;
    logic                     w_cpu_we;
    logic                     w_blocked;
    logic                     w_prot_hit;

    // Zero-extend MAR so the compare against the integer limit is unsigned.
    assign w_prot_hit = ({{(32-ADDRESS_WIDTH){1'b0}}, MAR} < PROT_LIMIT);

    // State register; reset always returns to the loader.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_LOAD;
        else     r_state <= w_state_nxt;
    end

    // Next state, loader transfer, and CPU write qualification.
    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        w_cpu_we    = 1'b0;
        w_blocked   = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_xfer = ld_valid;
                if (ld_valid && (ld_last || (r_ld_addr == LP_TOP)))
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_blocked = LP_WPROT_EN && RAMWr && w_prot_hit;
                w_cpu_we  = RAMWr && !w_blocked;
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Loader address and accepted-word count; the count saturates at full depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_addr      <= '0;
            r_loaded_count <= '0;
        end else if (w_xfer) begin
            r_ld_addr <= r_ld_addr + 1'b1;
            if (r_loaded_count != LP_FULL)
                r_loaded_count <= r_loaded_count + 1'b1;
        end
    end

    // RAM write port; contents survive reset so that a partial reload is possible.
    always_ff @(posedge clk) begin
        if (w_xfer)        r_mem[r_ld_addr] <= ld_data;
        else if (w_cpu_we) r_mem[MAR]       <= MDRIn;
    end

    // Registered read (read-before-write on the same address); held at zero while loading.
    always_ff @(posedge clk) begin
        if (rst)                  r_mdrout <= '0;
        else if (r_state == S_RUN) r_mdrout <= r_mem[MAR];
        else                      r_mdrout <= '0;
    end

    // One-cycle pulse per blocked CPU write; stays zero when protection is not built.
    always_ff @(posedge clk) begin
        if (rst) r_wr_fault <= 1'b0;
        else     r_wr_fault <= w_blocked;
    end

    assign MDROut       = r_mdrout;
    assign ld_ready     = (r_state == S_LOAD);
    assign cpu_rst      = (r_state == S_LOAD);
    assign loaded_count = r_loaded_count;
    assign wr_fault     = r_wr_fault;

endmodule

// File: tb/tb_fbu_ram_responder.sv
// Bench for fbu_ram_responder: a CPU-bus vector table, scoreboarded reads,
// and hand sequences covering the loader, reset, and write-protection corners.
module tb_fbu_ram_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] MAR;
    logic       RAMWr;
    logic [9:0] MDRIn;
    logic [9:0] MDROut;
    logic       ld_valid;
    logic [9:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       cpu_rst;
    logic [6:0] loaded_count;
    logic       wr_fault;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0] mar;
        logic       wr;
        logic [9:0] din;
        logic       chk;
        logic [9:0] exp;
    } vec_t;

    vec_t        tbl [12];
    logic [10:0] sb_q [$];

    fbu_ram_responder #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10), .PROT_LIMIT(32)) dut (
        .clk(clk), .rst(rst), .MAR(MAR), .RAMWr(RAMWr), .MDRIn(MDRIn), .MDROut(MDROut),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .cpu_rst(cpu_rst), .loaded_count(loaded_count), .wr_fault(wr_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] pat(int i);
        int t;
        t = i * 37 + 5;
        return t[9:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        RAMWr    = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_word(logic [9:0] d, logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic cpu_cycle(string name, logic [5:0] mar, logic wr, logic [9:0] din,
                             logic do_chk, logic [9:0] exp, logic exp_fault);
        logic [10:0] e;
        MAR   = mar;
        RAMWr = wr;
        MDRIn = din;
        sb_q.push_back({do_chk, exp});
        tick();
        RAMWr = 1'b0;
        e = sb_q.pop_front();
        if (e[10]) chk(name, {22'd0, MDROut}, {22'd0, e[9:0]});
        chk({name, "_fault"}, {31'd0, wr_fault}, {31'd0, exp_fault});
    endtask

    initial begin
        logic exp_prot;
`ifdef FBU_RAM_WPROT_EN
        exp_prot = 1'b1;
`else
        exp_prot = 1'b0;
`endif
        MAR = '0; MDRIn = '0; ld_data = '0;
        tbl[0]  = '{6'd1,  1'b0, 10'h000, 1'b1, 10'h2C5};
        tbl[1]  = '{6'd0,  1'b0, 10'h000, 1'b1, 10'h001};
        tbl[2]  = '{6'd2,  1'b0, 10'h000, 1'b1, 10'h180};
        tbl[3]  = '{6'd40, 1'b1, 10'h0F0, 1'b0, 10'h000};
        tbl[4]  = '{6'd40, 1'b1, 10'h155, 1'b1, 10'h0F0};
        tbl[5]  = '{6'd40, 1'b0, 10'h000, 1'b1, 10'h155};
        tbl[6]  = '{6'd41, 1'b1, 10'h2AA, 1'b0, 10'h000};
        tbl[7]  = '{6'd41, 1'b0, 10'h000, 1'b1, 10'h2AA};
        tbl[8]  = '{6'd40, 1'b0, 10'h3FF, 1'b1, 10'h155};
        tbl[9]  = '{6'd63, 1'b1, 10'h3C3, 1'b0, 10'h000};
        tbl[10] = '{6'd63, 1'b0, 10'h000, 1'b1, 10'h3C3};
        tbl[11] = '{6'd41, 1'b0, 10'h000, 1'b1, 10'h2AA};

        // Reset state
        do_reset();
        chk("rst_mdrout", {22'd0, MDROut}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_count", {25'd0, loaded_count}, 32'd0);
        chk("rst_wr_fault", {31'd0, wr_fault}, 32'd0);

        // Three-word load with ld_last
        load_word(10'h001, 1'b0);
        chk("ld3_count1", {25'd0, loaded_count}, 32'd1);
        chk("ld3_ready1", {31'd0, ld_ready}, 32'd1);
        load_word(10'h2C5, 1'b0);
        load_word(10'h180, 1'b1);
        chk("ld3_count", {25'd0, loaded_count}, 32'd3);
        chk("ld3_ready", {31'd0, ld_ready}, 32'd0);
        chk("ld3_cpu_rst", {31'd0, cpu_rst}, 32'd0);

        for (int i = 0; i < 12; i++)
            cpu_cycle($sformatf("tbl%0d", i), tbl[i].mar, tbl[i].wr, tbl[i].din,
                      tbl[i].chk, tbl[i].exp, 1'b0);

        // Loader ignored in RUN
        ld_valid = 1'b1; ld_data = 10'h3EE;
        tick();
        ld_valid = 1'b0;
        chk("run_ld_count", {25'd0, loaded_count}, 32'd3);
        chk("run_ld_ready", {31'd0, ld_ready}, 32'd0);
        cpu_cycle("run_ld_mem0", 6'd0, 1'b0, 10'h000, 1'b1, 10'h001, 1'b0);

        // Full 64-word load without ld_last
        do_reset();
        for (int i = 0; i < 64; i++) begin
            load_word(pat(i), 1'b0);
            if (i == 62) begin
                chk("ld64_count63", {25'd0, loaded_count}, 32'd63);
                chk("ld64_ready63", {31'd0, ld_ready}, 32'd1);
            end
        end
        chk("ld64_count", {25'd0, loaded_count}, 32'd64);
        chk("ld64_ready", {31'd0, ld_ready}, 32'd0);
        chk("ld64_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        load_word(10'h3FF, 1'b0);
        chk("ld65_count", {25'd0, loaded_count}, 32'd64);
        cpu_cycle("ld65_mem0", 6'd0, 1'b0, 10'h000, 1'b1, pat(0), 1'b0);
        cpu_cycle("ld64_mem63", 6'd63, 1'b0, 10'h000, 1'b1, pat(63), 1'b0);

        // Write protection boundary
        cpu_cycle("wp5_wr", 6'd5, 1'b1, 10'h3FF, 1'b1, pat(5), exp_prot);
        cpu_cycle("wp5_rd", 6'd5, 1'b0, 10'h000, 1'b1, exp_prot ? pat(5) : 10'h3FF, 1'b0);
        cpu_cycle("wp31_wr", 6'd31, 1'b1, 10'h0C3, 1'b1, pat(31), exp_prot);
        cpu_cycle("wp31_rd", 6'd31, 1'b0, 10'h000, 1'b1, exp_prot ? pat(31) : 10'h0C3, 1'b0);
        cpu_cycle("wp32_wr", 6'd32, 1'b1, 10'h111, 1'b1, pat(32), 1'b0);
        cpu_cycle("wp32_rd", 6'd32, 1'b0, 10'h000, 1'b1, 10'h111, 1'b0);

        // Reset during RUN keeps RAM; partial reload
        cpu_cycle("r50_wr", 6'd50, 1'b1, 10'h0AA, 1'b1, pat(50), 1'b0);
        do_reset();
        chk("rr_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rr_ready", {31'd0, ld_ready}, 32'd1);
        chk("rr_count", {25'd0, loaded_count}, 32'd0);
        chk("rr_mdrout", {22'd0, MDROut}, 32'd0);
        load_word(10'h123, 1'b1);
        chk("rr_count1", {25'd0, loaded_count}, 32'd1);
        cpu_cycle("rr_mem50", 6'd50, 1'b0, 10'h000, 1'b1, 10'h0AA, 1'b0);
        cpu_cycle("rr_mem0", 6'd0, 1'b0, 10'h000, 1'b1, 10'h123, 1'b0);
        cpu_cycle("rr_mem1", 6'd1, 1'b0, 10'h000, 1'b1, pat(1), 1'b0);

        // Gapped loader stream: valid 1,0,1,1
        do_reset();
        load_word(10'h0A1, 1'b0);
        chk("gap_count1", {25'd0, loaded_count}, 32'd1);
        ld_data = 10'h3EE;
        tick();
        chk("gap_count_idle", {25'd0, loaded_count}, 32'd1);
        load_word(10'h0A2, 1'b0);
        chk("gap_count2", {25'd0, loaded_count}, 32'd2);
        load_word(10'h0A3, 1'b1);
        chk("gap_count3", {25'd0, loaded_count}, 32'd3);
        chk("gap_ready", {31'd0, ld_ready}, 32'd0);
        cpu_cycle("gap_mem0", 6'd0, 1'b0, 10'h000, 1'b1, 10'h0A1, 1'b0);
        cpu_cycle("gap_mem1", 6'd1, 1'b0, 10'h000, 1'b1, 10'h0A2, 1'b0);
        cpu_cycle("gap_mem2", 6'd2, 1'b0, 10'h000, 1'b1, 10'h0A3, 1'b0);
        cpu_cycle("gap_mem3", 6'd3, 1'b0, 10'h000, 1'b1, pat(3), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
